// File: rtl/expr_checker.sv
// expr_checker: streaming ASCII arithmetic-expression recogniser.
// Optional build macro: EXPR_SPACE_EN (ignore 0x20 outside the error state).
module expr_checker #(
    parameter int MAX_DEPTH   = 7,
    parameter int DEPTH_W     = 3,
    parameter int MULTI_DIGIT = 1,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               restart,
    input  logic               in_valid,
    input  logic [7:0]         in,
    output logic               out,
    output logic               err,
    output logic [DEPTH_W-1:0] depth,
    output logic [CNT_W-1:0]   op_cnt
);

    typedef enum logic [2:0] {
        S_EMPTY,
        S_EXPECT,
        S_NUM,
        S_CLOSE,
        S_ERR
    } state_t;

    state_t             state, state_nx;
    logic [DEPTH_W-1:0] depth_q, depth_nx;
    logic [CNT_W-1:0]   cnt_q, cnt_nx;

    logic is_dig, is_op, is_lp, is_rp, is_sp;
    logic at_max, at_zero;
    logic [CNT_W-1:0] cnt_inc;

    // classify the incoming byte
    always_comb begin
        is_dig = (in >= 8'h30) && (in <= 8'h39);
        is_op  = (in == 8'h2B) || (in == 8'h2D) ||
                 (in == 8'h2A) || (in == 8'h2F);
        is_lp  = (in == 8'h28);
        is_rp  = (in == 8'h29);
`ifdef EXPR_SPACE_EN
        is_sp  = (in == 8'h20);
`else
        is_sp  = 1'b0;
`endif
    end

    // nesting bounds and saturating operator increment
    always_comb begin
        at_max  = (depth_q == DEPTH_W'(MAX_DEPTH));
        at_zero = (depth_q == '0);
        cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // state register; restart is a synchronous return to reset
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state   <= S_EMPTY;
            depth_q <= '0;
            cnt_q   <= '0;
        end else if (restart) begin
            state   <= S_EMPTY;
            depth_q <= '0;
            cnt_q   <= '0;
        end else begin
            state   <= state_nx;
            depth_q <= depth_nx;
            cnt_q   <= cnt_nx;
        end
    end

    // grammar transitions; ERR absorbs and freezes counters
    always_comb begin
        state_nx = state;
        depth_nx = depth_q;
        cnt_nx   = cnt_q;
        if (in_valid && (state != S_ERR) && !is_sp) begin
            case (state)
                S_EMPTY, S_EXPECT: begin
                    if (is_dig) begin
                        state_nx = S_NUM;
                    end else if (is_lp && !at_max) begin
                        state_nx = S_EXPECT;
                        depth_nx = depth_q + DEPTH_W'(1);
                    end else begin
                        state_nx = S_ERR;
                    end
                end
                S_NUM, S_CLOSE: begin
                    if (is_dig && (state == S_NUM) && (MULTI_DIGIT != 0)) begin
                        state_nx = S_NUM;
                    end else if (is_op) begin
                        state_nx = S_EXPECT;
                        cnt_nx   = cnt_inc;
                    end else if (is_rp && !at_zero) begin
                        state_nx = S_CLOSE;
                        depth_nx = depth_q - DEPTH_W'(1);
                    end else begin
                        state_nx = S_ERR;
                    end
                end
                default: state_nx = S_ERR;
            endcase
        end
    end

    // Moore outputs decoded from the registers
    always_comb begin
        out    = ((state == S_NUM) || (state == S_CLOSE)) && at_zero;
        err    = (state == S_ERR);
        depth  = depth_q;
        op_cnt = cnt_q;
    end

endmodule

// File: tb/tb_expr_checker.sv
// tb_expr_checker: randomized and directed checks of expr_checker
// against a prefix-rescanning reference model.
module tb_expr_checker;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       restart;
    logic       in_valid;
    logic [7:0] in;

    logic       o1, e1, o0, e0;
    logic [2:0] d1, d0;
    logic [7:0] c1, c0;

    int errors = 0;
    int checks = 0;

    logic [7:0] hist[$];

    always #5 clk = ~clk;

    expr_checker #(.MAX_DEPTH(7), .DEPTH_W(3), .MULTI_DIGIT(1), .CNT_W(8)) u_md (
        .clk(clk), .clr_n(clr_n), .restart(restart), .in_valid(in_valid),
        .in(in), .out(o1), .err(e1), .depth(d1), .op_cnt(c1)
    );

    expr_checker #(.MAX_DEPTH(7), .DEPTH_W(3), .MULTI_DIGIT(0), .CNT_W(8)) u_sd (
        .clk(clk), .clr_n(clr_n), .restart(restart), .in_valid(in_valid),
        .in(in), .out(o0), .err(e0), .depth(d0), .op_cnt(c0)
    );

    wire [12:0] obs1 = {o1, e1, d1, c1};
    wire [12:0] obs0 = {o0, e0, d0, c0};

    // Rescan the whole accepted prefix from the grammar rules.
    // prev: 0 = operand expected, 1 = after digit, 2 = after ')'
    function automatic logic [12:0] model(input bit multi);
        int         prev = 0;
        logic [2:0] d = '0;
        logic [7:0] n = '0;
        bit         e = 0;
        bit         o;
        foreach (hist[i]) begin
            logic [7:0] c;
            bit dig, op, lp, rp;
            if (e) break;
            c = hist[i];
`ifdef EXPR_SPACE_EN
            if (c == 8'h20) continue;
`endif
            dig = (c >= "0") && (c <= "9");
            op  = (c == "+") || (c == "-") || (c == "*") || (c == "/");
            lp  = (c == "(");
            rp  = (c == ")");
            if (prev == 0) begin
                if (dig) prev = 1;
                else if (lp && d != 3'd7) d = d + 3'd1;
                else e = 1;
            end else begin
                if (dig && prev == 1 && multi) prev = 1;
                else if (op) begin
                    if (n != 8'hFF) n = n + 8'd1;
                    prev = 0;
                end else if (rp && d != 0) begin
                    d = d - 3'd1;
                    prev = 2;
                end else e = 1;
            end
        end
        o = !e && (prev != 0) && (d == 0);
        return {o, e, d, n};
    endfunction

    task automatic step(input logic [7:0] b, input bit v, input bit r);
        @(negedge clk);
        in       = b;
        in_valid = v;
        restart  = r;
        @(posedge clk);
        #1;
        if (r) hist.delete();
        else if (v) hist.push_back(b);
        in_valid = 1'b0;
        restart  = 1'b0;
    endtask

    task automatic test_reset();
        clr_n = 1'b0; restart = 1'b0; in_valid = 1'b0; in = 8'h00;
        #12;
        checks += 2;
        if (obs1 !== 13'h0) begin errors++; $display("FAIL reset md: got %h want 0", obs1); end
        if (obs0 !== 13'h0) begin errors++; $display("FAIL reset sd: got %h want 0", obs0); end
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    task automatic test_basic();
        string s = "0*1+2";
        logic [4:0] exp_out = 5'b10101;
        for (int i = 0; i < s.len(); i++) begin
            step(s[i], 1, 0);
            checks += 2;
            if (o1 !== exp_out[4-i]) begin errors++; $display("FAIL basic out[%0d]: got %b want %b", i, o1, exp_out[4-i]); end
            if (obs1 !== model(1)) begin errors++; $display("FAIL basic md[%0d]: got %h want %h", i, obs1, model(1)); end
        end
        checks += 2;
        if (c1 !== 8'd2 || e1 !== 1'b0) begin errors++; $display("FAIL basic cnt: got %0d err %b want 2 0", c1, e1); end
        if (obs0 !== model(0)) begin errors++; $display("FAIL basic sd: got %h want %h", obs0, model(0)); end
    endtask

    task automatic test_error();
        string s = "0*1++1";
        step(8'h00, 0, 1);
        for (int i = 0; i < s.len(); i++) begin
            step(s[i], 1, 0);
            checks += 1;
            if (obs1 !== model(1)) begin errors++; $display("FAIL error md[%0d]: got %h want %h", i, obs1, model(1)); end
        end
        checks += 1;
        if (e1 !== 1'b1 || o1 !== 1'b0 || c1 !== 8'd2) begin errors++; $display("FAIL error sticky: got err %b out %b cnt %0d want 1 0 2", e1, o1, c1); end
        step(8'h00, 0, 1);
        checks += 1;
        if (e1 !== 1'b0 || c1 !== 8'd0) begin errors++; $display("FAIL error restart: got err %b cnt %0d want 0 0", e1, c1); end
    endtask

    task automatic test_paren();
        string s = "(1+(2))";
        logic [2:0] dexp[7] = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd1, 3'd0};
        step(8'h00, 0, 1);
        for (int i = 0; i < s.len(); i++) begin
            step(s[i], 1, 0);
            checks += 2;
            if (d1 !== dexp[i]) begin errors++; $display("FAIL paren depth[%0d]: got %0d want %0d", i, d1, dexp[i]); end
            if (obs1 !== model(1)) begin errors++; $display("FAIL paren md[%0d]: got %h want %h", i, obs1, model(1)); end
        end
        checks += 1;
        if (o1 !== 1'b1) begin errors++; $display("FAIL paren out: got %b want 1", o1); end
        step(")", 1, 0);
        checks += 1;
        if (e1 !== 1'b1 || d1 !== 3'd0) begin errors++; $display("FAIL paren extra: got err %b depth %0d want 1 0", e1, d1); end
    endtask

    task automatic test_depth();
        step(8'h00, 0, 1);
        for (int i = 0; i < 8; i++) begin
            step("(", 1, 0);
            checks += 1;
            if (obs1 !== model(1)) begin errors++; $display("FAIL depth md[%0d]: got %h want %h", i, obs1, model(1)); end
        end
        checks += 1;
        if (e1 !== 1'b1 || d1 !== 3'd7) begin errors++; $display("FAIL depth max: got err %b depth %0d want 1 7", e1, d1); end
    endtask

    task automatic test_multi();
        string s = "12*34";
        step(8'h00, 0, 1);
        for (int i = 0; i < s.len(); i++) begin
            step(s[i], 1, 0);
            checks += 2;
            if (obs1 !== model(1)) begin errors++; $display("FAIL multi md[%0d]: got %h want %h", i, obs1, model(1)); end
            if (obs0 !== model(0)) begin errors++; $display("FAIL multi sd[%0d]: got %h want %h", i, obs0, model(0)); end
        end
        checks += 2;
        if (o1 !== 1'b1 || c1 !== 8'd1) begin errors++; $display("FAIL multi md end: got out %b cnt %0d want 1 1", o1, c1); end
        if (e0 !== 1'b1 || c0 !== 8'd0) begin errors++; $display("FAIL multi sd end: got err %b cnt %0d want 1 0", e0, c0); end
    endtask

    task automatic test_gaps();
        string s = "12*34";
        step(8'h00, 0, 1);
        for (int i = 0; i < s.len(); i++) begin
            int gap = $urandom_range(3, 0);
            for (int g = 0; g < gap; g++) step(8'($urandom), 0, 0);
            step(s[i], 1, 0);
            checks += 1;
            if (obs1 !== model(1)) begin errors++; $display("FAIL gaps md[%0d]: got %h want %h", i, obs1, model(1)); end
        end
        checks += 1;
        if (o1 !== 1'b1 || c1 !== 8'd1 || e1 !== 1'b0) begin errors++; $display("FAIL gaps end: got out %b cnt %0d err %b want 1 1 0", o1, c1, e1); end
    endtask

    task automatic test_restart_valid();
        step(8'h00, 0, 1);
        step("1", 1, 0);
        step("+", 1, 0);
        step(")", 1, 1);
        checks += 1;
        if (obs1 !== 13'h0) begin errors++; $display("FAIL rstvalid drop: got %h want 0", obs1); end
        step("2", 1, 0);
        checks += 1;
        if (o1 !== 1'b1 || c1 !== 8'd0) begin errors++; $display("FAIL rstvalid fresh: got out %b cnt %0d want 1 0", o1, c1); end
    endtask

    task automatic test_space();
        string s = "1 + 2";
        step(8'h00, 0, 1);
        for (int i = 0; i < s.len(); i++) begin
            step(s[i], 1, 0);
            checks += 1;
            if (obs1 !== model(1)) begin errors++; $display("FAIL space md[%0d]: got %h want %h", i, obs1, model(1)); end
        end
        checks += 1;
`ifdef EXPR_SPACE_EN
        if (o1 !== 1'b1 || e1 !== 1'b0) begin errors++; $display("FAIL space end: got out %b err %b want 1 0", o1, e1); end
`else
        if (o1 !== 1'b0 || e1 !== 1'b1 || c1 !== 8'd0) begin errors++; $display("FAIL space end: got out %b err %b cnt %0d want 0 1 0", o1, e1, c1); end
`endif
    endtask

    task automatic test_clr();
        step(8'h00, 0, 1);
        step("(", 1, 0);
        step("1", 1, 0);
        step("+", 1, 0);
        #2;
        clr_n = 1'b0;
        #1;
        hist.delete();
        checks += 2;
        if (obs1 !== 13'h0) begin errors++; $display("FAIL clr md: got %h want 0", obs1); end
        if (obs0 !== 13'h0) begin errors++; $display("FAIL clr sd: got %h want 0", obs0); end
        @(negedge clk);
        clr_n = 1'b1;
        step("7", 1, 0);
        checks += 1;
        if (o1 !== 1'b1 || d1 !== 3'd0) begin errors++; $display("FAIL clr restart: got out %b depth %0d want 1 0", o1, d1); end
    endtask

    task automatic test_saturate();
        step(8'h00, 0, 1);
        for (int i = 0; i < 300; i++) begin
            step("1", 1, 0);
            step("+", 1, 0);
        end
        step("9", 1, 0);
        checks += 2;
        if (c1 !== 8'hFF || o1 !== 1'b1) begin errors++; $display("FAIL sat cnt: got %0d out %b want 255 1", c1, o1); end
        if (obs1 !== model(1)) begin errors++; $display("FAIL sat md: got %h want %h", obs1, model(1)); end
    endtask

    task automatic test_random();
        string alpha = "0123456789+-*/()(( x";
        step(8'h00, 0, 1);
        for (int i = 0; i < 1500; i++) begin
            logic [7:0] b = alpha[$urandom_range(alpha.len() - 1, 0)];
            bit v = ($urandom_range(3, 0) != 0);
            bit r = ($urandom_range(24, 0) == 0);
            step(b, v, r);
            checks += 2;
            if (obs1 !== model(1)) begin errors++; $display("FAIL rand md[%0d]: got %h want %h", i, obs1, model(1)); end
            if (obs0 !== model(0)) begin errors++; $display("FAIL rand sd[%0d]: got %h want %h", i, obs0, model(0)); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_error();
        test_paren();
        test_depth();
        test_multi();
        test_gaps();
        test_restart_valid();
        test_space();
        test_clr();
        test_saturate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
